// File: rtl/sc_apc_accum_if.sv
// Stream-in / result-out bundle for sc_apc_accum.
// slave is the accumulator side; master is the generator / consumer side.
interface sc_apc_accum_if #(
  parameter int unsigned LANES = 4,
  parameter int unsigned SUM_W = 7
);
  logic             i_isgen;
  logic [LANES-1:0] i_sn_bit;
  logic [LANES-1:0] i_w_bit;
  logic [SUM_W:0]   o_sum;
  logic [4:0]       o_nsamp;
  logic             o_valid;
  logic             o_ovf;
  logic             o_busy;

  modport master (
    output i_isgen, i_sn_bit, i_w_bit,
    input  o_sum, o_nsamp, o_valid, o_ovf, o_busy
  );

  modport slave (
    input  i_isgen, i_sn_bit, i_w_bit,
    output o_sum, o_nsamp, o_valid, o_ovf, o_busy
  );
endinterface

// File: rtl/sc_apc_accum.sv
// Stochastic lane-product popcount accumulated over one i_isgen window; one result pulse per window.
// Define SC_APC_BIPOLAR_EN for XNOR products and a signed 2*acc - LANES*n result.
module sc_apc_accum #(
  parameter int unsigned LANES = 4,
  parameter int unsigned WIN   = 16,
  parameter int unsigned SUM_W = 7
) (
  input logic           i_clk_apc,
  input logic           i_rst_apc,
  sc_apc_accum_if.slave bus
);
  localparam int unsigned ResW = SUM_W + 1;

  typedef enum logic [1:0] {StIdle, StAcc, StHold} state_e;

  state_e           state_q, state_d;
  logic [LANES-1:0] prod;
  logic [SUM_W-1:0] cnt;
  logic [SUM_W-1:0] acc_q, acc_d;
  logic [4:0]       n_q, n_d;
  logic             pub, pub_ovf;
  logic [ResW-1:0]  result;

  // Result is captured at the publish edge so a window starting on the next edge cannot disturb it.
  logic             pend_q, pend_ovf_q;
  logic [ResW-1:0]  pend_sum_q;
  logic [4:0]       pend_n_q;

  logic [ResW-1:0]  sum_q;
  logic [4:0]       nsamp_q;
  logic             valid_q, ovf_q, busy_q;

`ifdef SC_APC_BIPOLAR_EN
  assign prod   = ~(bus.i_sn_bit ^ bus.i_w_bit);
  assign result = {acc_q, 1'b0} - ResW'(LANES) * ResW'(n_q);
`else
  assign prod   = bus.i_sn_bit & bus.i_w_bit;
  assign result = {1'b0, acc_q};
`endif

  always_comb begin
    cnt = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      cnt = cnt + SUM_W'(prod[k]);
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    n_d     = n_q;
    pub     = 1'b0;
    pub_ovf = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.i_isgen) begin
          state_d = StAcc;
          acc_d   = cnt;
          n_d     = 5'd1;
        end
      end
      StAcc: begin
        if (!bus.i_isgen) begin
          pub     = 1'b1;
          state_d = StIdle;
        end else if (n_q == 5'(WIN)) begin
          pub     = 1'b1;
          pub_ovf = 1'b1;
          state_d = StHold;
        end else begin
          acc_d = acc_q + cnt;
          n_d   = n_q + 5'd1;
        end
      end
      StHold: begin
        if (!bus.i_isgen) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk_apc) begin
    if (i_rst_apc) begin
      state_q    <= StIdle;
      acc_q      <= '0;
      n_q        <= '0;
      pend_q     <= 1'b0;
      pend_ovf_q <= 1'b0;
      pend_sum_q <= '0;
      pend_n_q   <= '0;
      sum_q      <= '0;
      nsamp_q    <= '0;
      valid_q    <= 1'b0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      n_q     <= n_d;
      pend_q  <= pub;
      if (pub) begin
        pend_sum_q <= result;
        pend_n_q   <= n_q;
        pend_ovf_q <= pub_ovf;
      end
      valid_q <= pend_q;
      if (pend_q) begin
        sum_q   <= pend_sum_q;
        nsamp_q <= pend_n_q;
        ovf_q   <= pend_ovf_q;
      end
      busy_q <= (state_q != StIdle);
    end
  end

  assign bus.o_sum   = sum_q;
  assign bus.o_nsamp = nsamp_q;
  assign bus.o_valid = valid_q;
  assign bus.o_ovf   = ovf_q;
  assign bus.o_busy  = busy_q;
endmodule

// File: tb/tb_sc_apc_accum.sv
// Directed and random windows for sc_apc_accum, checked against a window-level sample-list model.
// Follows SC_APC_BIPOLAR_EN so the same bench checks either product/result mode.
module tb_sc_apc_accum;
  localparam int LANES = 4;
  localparam int WIN   = 16;
  localparam int SUM_W = 7;

  typedef struct {
    int at;
    int sum;
    int n;
    bit ovf;
  } pulse_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  sc_apc_accum_if #(.LANES(LANES), .SUM_W(SUM_W)) bus ();

  sc_apc_accum #(.LANES(LANES), .WIN(WIN), .SUM_W(SUM_W)) dut (
    .i_clk_apc (clk),
    .i_rst_apc (rst),
    .bus       (bus)
  );

  pulse_t exp_q[$];
  int     win_q[$];
  int     mode;  // 0 idle, 1 collecting, 2 discarding after overflow
  int     cyc;
  int     total;
  int     bad;
  int     last_sum;
  int     last_n;
  bit     last_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d (cycle %0d)", tag, obs, want, cyc);
    end
  endtask

  function automatic int win_result();
    int s = 0;
    foreach (win_q[i]) s += win_q[i];
`ifdef SC_APC_BIPOLAR_EN
    return 2 * s - LANES * win_q.size();
`else
    return s;
`endif
  endfunction

  task automatic publish(input bit ovf);
    pulse_t pl;
    pl.at  = cyc + 2;
    pl.sum = win_result();
    pl.n   = win_q.size();
    pl.ovf = ovf;
    exp_q.push_back(pl);
  endtask

  task automatic check_outputs(input bit busy_exp);
    if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
      chk("valid_pulse", 32'(bus.o_valid), 32'd1);
      chk("sum", 32'(bus.o_sum), 32'(exp_q[0].sum & 32'hFF));
      chk("nsamp", 32'(bus.o_nsamp), 32'(exp_q[0].n));
      chk("ovf", 32'(bus.o_ovf), 32'(exp_q[0].ovf));
      last_sum = exp_q[0].sum & 32'hFF;
      last_n   = exp_q[0].n;
      last_ovf = exp_q[0].ovf;
      void'(exp_q.pop_front());
    end else begin
      chk("valid_idle", 32'(bus.o_valid), 32'd0);
      chk("sum_hold", 32'(bus.o_sum), 32'(last_sum));
      chk("nsamp_hold", 32'(bus.o_nsamp), 32'(last_n));
      chk("ovf_hold", 32'(bus.o_ovf), 32'(last_ovf));
    end
    chk("busy", 32'(bus.o_busy), 32'(busy_exp));
  endtask

  task automatic step(input bit g, input logic [3:0] sn, input logic [3:0] w);
    logic [3:0] p;
    int         c;
    bit         busy_exp;
    @(negedge clk);
    rst          = 1'b0;
    bus.i_isgen  = g;
    bus.i_sn_bit = sn;
    bus.i_w_bit  = w;
`ifdef SC_APC_BIPOLAR_EN
    p = ~(sn ^ w);
`else
    p = sn & w;
`endif
    c        = $countones(p);
    busy_exp = (mode != 0);
    case (mode)
      0: if (g) begin
        win_q.delete();
        win_q.push_back(c);
        mode = 1;
      end
      1: if (!g) begin
        publish(1'b0);
        mode = 0;
      end else if (win_q.size() == WIN) begin
        publish(1'b1);
        mode = 2;
      end else begin
        win_q.push_back(c);
      end
      default: if (!g) mode = 0;
    endcase
    @(posedge clk);
    #1;
    cyc++;
    check_outputs(busy_exp);
  endtask

  task automatic reset_cycle();
    @(negedge clk);
    rst         = 1'b1;
    bus.i_isgen = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    mode = 0;
    win_q.delete();
    exp_q.delete();
    last_sum = 0;
    last_n   = 0;
    last_ovf = 1'b0;
    chk("rst_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_sum", 32'(bus.o_sum), 32'd0);
    chk("rst_nsamp", 32'(bus.o_nsamp), 32'd0);
    chk("rst_ovf", 32'(bus.o_ovf), 32'd0);
    chk("rst_busy", 32'(bus.o_busy), 32'd0);
  endtask

  task automatic run(input int hi, input logic [3:0] sn, input logic [3:0] w, input int lo);
    for (int i = 0; i < hi; i++) step(1'b1, sn, w);
    for (int i = 0; i < lo; i++) step(1'b0, sn, w);
  endtask

  initial begin
    rst          = 1'b1;
    bus.i_isgen  = 1'b0;
    bus.i_sn_bit = '0;
    bus.i_w_bit  = '0;
    mode = 0; cyc = 0; total = 0; bad = 0;
    last_sum = 0; last_n = 0; last_ovf = 1'b0;
    reset_cycle();
    reset_cycle();

    run(16, 4'b1111, 4'b1111, 3);
    run(10, 4'b1111, 4'b0101, 3);
    run(20, 4'b0001, 4'b0001, 3);
    run(3, 4'b0011, 4'b0011, 1);
    run(2, 4'b1111, 4'b1111, 3);
    run(16, 4'b1010, 4'b0101, 3);
    run(16, 4'b1100, 4'b1111, 3);
    run(1, 4'b1111, 4'b1111, 1);
    run(1, 4'b0110, 4'b0110, 3);

    // Abort in the 5th cycle of a window: no pulse may follow.
    run(4, 4'b1111, 4'b1111, 0);
    reset_cycle();
    run(0, 4'b0000, 4'b0000, 4);

    for (int k = 0; k < 40; k++) begin
      int len  = int'($urandom_range(1, 20));
      int gap  = int'($urandom_range(1, 3));
      bit do_r = ($urandom_range(0, 9) == 0);
      for (int i = 0; i < len; i++) begin
        if (do_r && i == len / 2) begin
          reset_cycle();
          break;
        end
        step(1'b1, 4'($urandom), 4'($urandom));
      end
      for (int i = 0; i < gap; i++) step(1'b0, 4'($urandom), 4'($urandom));
    end

    run(0, 4'b0000, 4'b0000, 4);
    chk("drain", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
